tt_um_hoene_led_pwm_nch: RTL
============================

TT_UM_HOENE_LED_PWM_NCH -- requirements
Module: tt_um_hoene_led_pwm_nch

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent PWM channels, legal range 1..8.
REQ-002 Parameter WIDTH, default 10: duty and counter width in bits, legal range 4..12.
REQ-003 Parameter PRESCALE, default 1: clk cycles per PWM tick, legal range 1..256.
REQ-004 Parameter STAGGER, default 1: 1 = per-channel phase offset enabled; 0 = all channels in phase.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  1 = PWM running; 0 = counter halted, outputs low.
REQ-008 load  input  1  single-cycle strobe; captures data into the shadow register.
REQ-009 data  input  CHANNELS*WIDTH  duty values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 out  output  CHANNELS  registered PWM outputs; bit i belongs to channel i.
REQ-011 period_start  output  1  one-cycle pulse on every period commit.
REQ-012 pending  output  1  high while shadow data waits for commit.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 while enable=1; tick = prescaler at PRESCALE-1; PRESCALE=1 means tick every clk.
REQ-014 Period counter cnt (WIDTH bits) SHALL increment on tick and wrap from 2^WIDTH-1 to 0; period = 2^WIDTH ticks.
REQ-015 Channel phase SHALL be ph_i = (cnt + i*floor(2^WIDTH/CHANNELS)) mod 2^WIDTH if STAGGER=1, else ph_i = cnt.
REQ-016 out[i] SHALL be registered as (ph_i < active_i), visible one clk after cnt changes; duty 0 = constant low; duty 2^WIDTH-1 = low exactly 1 tick per period.
REQ-017 load=1 SHALL capture data into shadow and set pending=1 on the next clk edge; a later load before commit overwrites the shadow (last wins).
REQ-018 Commit SHALL occur on the tick where cnt wraps to 0: active <= shadow if pending=1, pending <= 0, period_start=1 for that one clk; with pending=0, active is unchanged and period_start still pulses.
REQ-019 On load and commit in the same cycle, active SHALL take the data input of that cycle directly, and pending SHALL end at 0.
REQ-020 While enable=0: prescaler and cnt held at 0, out=0, period_start=0; load SHALL write active directly (bypass shadow) and clear pending.
REQ-021 On enable rising, counting SHALL restart from cnt=0 with no period_start pulse for that first cycle.
REQ-022 Duty and comparison arithmetic SHALL be unsigned WIDTH bits; no output glitch beyond the defined compare.

Reset
REQ-023 rst_n=0 SHALL immediately force out=0, period_start=0, pending=0, cnt=0, prescaler=0, all active and shadow registers=0.
REQ-024 Reset asserted mid-period SHALL discard pending data; after release, operation restarts as from power-up.
REQ-025 Release of rst_n SHALL be treated as synchronous to clk by the instantiating logic; no internal synchronizer is required.

Verification (CHANNELS=3, WIDTH=4, PRESCALE=1, STAGGER=0 unless stated)
REQ-026 enable=0, load with duties {5,0,15} -> active set immediately, pending stays 0; after enable=1, per 16-clk period: out[0] high 5 clk, out[1] never high, out[2] high 15 clk.
REQ-027 Running with duty 8; load duty 3 mid-period -> pending=1, out[0] keeps 8-clk high time until wrap; period_start pulses, next period high 3 clk, pending=0.
REQ-028 Two loads (4 then 9) inside one period -> committed duty is 9; load coincident with wrap tick -> new value active in that period, pending=0.
REQ-029 STAGGER=1, all duties 8 -> rising edges of out[0], out[1], out[2] spaced 5 clk apart (offset floor(16/3)=5).
REQ-030 PRESCALE=4, duty 2 -> out high 8 clk per 64-clk period; period_start every 64 clk.
REQ-031 Assert rst_n low mid-period with pending=1 -> out, pending, period_start go to 0 at once, without waiting for a clk edge; after release, all channels remain low until a new load.

Source files
------------

// File: rtl/tt_um_hoene_led_pwm_nch.sv
// ----------------------------------------------------------------------------
// tt_um_hoene_led_pwm_nch -- multi-channel LED PWM with shadowed duty update
//
// A shared prescaler and period counter drive CHANNELS independent compare
// lanes. New duty values are written into a shadow register by a one-cycle
// load strobe and committed to the active set when the period counter wraps,
// so a running PWM period is never cut short or stretched by an update.
// Optionally each channel's phase is offset by i*floor(2^WIDTH/CHANNELS) to
// spread LED switching edges across the period.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (release assumed synchronous)
//   enable        1 = run; 0 = counters held at 0, outputs low, loads go
//                 straight to the active set
//   load          one-cycle strobe capturing data
//   data          CHANNELS*WIDTH duty values, channel i at [i*WIDTH +: WIDTH]
//   out           registered PWM outputs, bit i = channel i
//   period_start  one-cycle pulse in the cycle after each commit (cnt == 0)
//   pending       shadow holds data not yet committed
// ----------------------------------------------------------------------------

// Per-channel compare lane: phase = cnt + OFFSET (mod 2^WIDTH), output is the
// registered unsigned compare against the channel's active duty.
module tt_um_hoene_led_pwm_nch_lane #(
  parameter int               WIDTH  = 10,
  parameter logic [WIDTH-1:0] OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             out
);
  logic [WIDTH-1:0] ph;

  // WIDTH-bit sum drops the carry, giving the modulo-2^WIDTH phase.
  assign ph = cnt + OFFSET;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= run && (ph < duty);
  end
endmodule

module tt_um_hoene_led_pwm_nch #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1,
  parameter int STAGGER  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start,
  output logic                      pending
);
  // Prescaler width; PRESCALE=1 still gets a 1-bit register that stays 0.
  localparam int               PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST  = PSW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;
  localparam int               STEP     = (2 ** WIDTH) / CHANNELS;

  logic [PSW-1:0]                    psc;
  logic [WIDTH-1:0]                  cnt;
  logic                              tick;
  logic                              wrap;
  logic [CHANNELS-1:0][WIDTH-1:0]    data_v;
  logic [CHANNELS-1:0][WIDTH-1:0]    shadow;
  logic [CHANNELS-1:0][WIDTH-1:0]    active;

  // Packed view of the flat bus: element i lands on bits [i*WIDTH +: WIDTH].
  assign data_v = data;

  assign tick = enable && (psc == PS_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  // Prescaler and period counter. Holding both at 0 while disabled makes a
  // re-enable start a fresh period; since no wrap happens on that first
  // tick, no period_start pulse is produced for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      cnt <= '0;
    end else if (!enable) begin
      psc <= '0;
      cnt <= '0;
    end else begin
      psc <= (psc == PS_LAST) ? '0 : psc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Shadow/active duty registers.
  //   disabled      : load bypasses the shadow, nothing to protect
  //   wrap (commit) : a coincident load wins over older shadow data
  //   otherwise     : load parks data in the shadow until the next wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (!enable) begin
      if (load) begin
        active  <= data_v;
        pending <= 1'b0;
      end
    end else if (wrap) begin
      if (load)         active <= data_v;
      else if (pending) active <= shadow;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= data_v;
      pending <= 1'b1;
    end
  end

  // Registered at the commit edge, so the pulse coincides with cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_start <= 1'b0;
    else        period_start <= wrap;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [WIDTH-1:0] OFF = (STAGGER != 0) ? WIDTH'(i * STEP) : '0;

    tt_um_hoene_led_pwm_nch_lane #(
      .WIDTH  (WIDTH),
      .OFFSET (OFF)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (enable),
      .cnt    (cnt),
      .duty   (active[i]),
      .out    (out[i])
    );
  end
endmodule
